// File: rtl/pc_pkg.sv
// Shared definitions for the PC generation unit.
//   pcsrc_t : next-PC source select encoding
//   PC_STEP : sequential instruction stride in bytes
package pc_pkg;

  typedef enum logic [1:0] {
    PC_INC  = 2'b00,
    PC_BR   = 2'b01,
    PC_JALR = 2'b10,
    PC_RET  = 2'b11
  } pcsrc_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack with saturating occupancy count.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears pointer/count)
//   push            : write data at the slot above top, advance pointer
//   pop             : drop top entry
//   replace         : overwrite top entry in place (pointer/count unchanged)
//   data            : value for push/replace
//   top             : current top entry (valid when !empty)
//   empty, full     : decoded from the registered count
// When full, a push overwrites the oldest entry; the count stays at DEPTH.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;      // next free slot; top lives at ptr-1
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    count;

  assign top_idx = ptr - PW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));

  // Pointer and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Entry storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push)         mem[ptr]     <= data;
      else if (replace) mem[top_idx] <= data;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// PC generation unit: PC register, target selection (sequential, branch,
// jalr, predicted return) and return-address stack management.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (priority over en)
//   en            : 1 advances the PC, 0 holds all state
//   PCsrc         : 00 inc, 01 branch, 10 jalr, 11 return
//   ImmOp         : sign-extended immediate
//   rs1_val       : register operand for jalr/return
//   is_call       : instruction links; pushes PC+4 (ignored with PCsrc=00)
//   PC            : current PC (registered)
//   ras_empty     : RAS holds no entries
//   ras_full      : RAS holds RAS_DEPTH entries
//   ret_mismatch  : one-cycle pulse, predicted return differed from jalr target
//   trap          : one-cycle pulse, misaligned target redirected to TRAP_VEC
// Optional feature macro: MISALIGN_TRAP_EN (misaligned-target trap).
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(32'h0000_0010)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic             is_call,
  output logic [WIDTH-1:0] PC,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ret_mismatch,
  output logic             trap
);

  pcsrc_t           src;
  logic [WIDTH-1:0] inc_t, br_t, jr_sum, jr_t, target, pc_next, ras_top;
  logic             misaligned, use_ras;
  logic             push, pop, replace, mismatch_next;

  assign src    = pcsrc_t'(PCsrc);
  assign inc_t  = PC + WIDTH'(PC_STEP);
  assign br_t   = PC + ImmOp;
  assign jr_sum = rs1_val + ImmOp;
  assign jr_t   = {jr_sum[WIDTH-1:1], 1'b0};

  // Return prediction is only available when the stack holds something
  assign use_ras = (src == PC_RET) && !ras_empty;

  always_comb begin
    target = inc_t;
    case (src)
      PC_INC:  target = inc_t;
      PC_BR:   target = br_t;
      PC_JALR: target = jr_t;
      PC_RET:  target = use_ras ? ras_top : jr_t;
      default: target = inc_t;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (src != PC_INC) && (target[1:0] != 2'b00);
  assign pc_next    = misaligned ? TRAP_VEC : target;
`else
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
  assign misaligned      = 1'b0;
  assign pc_next         = target;
`endif

  // Stack operations; a linking return on a non-empty stack swaps the top
  always_comb begin
    push          = 1'b0;
    pop           = 1'b0;
    replace       = 1'b0;
    mismatch_next = 1'b0;
    if (en && !misaligned) begin
      if (src == PC_RET && use_ras) begin
        mismatch_next = (ras_top != jr_t);
        replace       = is_call;
        pop           = !is_call;
      end else if (src != PC_INC) begin
        push = is_call;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC           <= RESET_PC;
      ret_mismatch <= 1'b0;
      trap         <= 1'b0;
    end else begin
      if (en) PC <= pc_next;
      ret_mismatch <= mismatch_next;
      trap         <= en && misaligned;
    end
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .replace (replace),
    .data    (inc_t),
    .top     (ras_top),
    .empty   (ras_empty),
    .full    (ras_full)
  );

endmodule
